// File: rtl/dispatch_controller.sv
// dispatch_controller
//   Sequencer in front of the instruction issuer. Fetched instructions are
//   buffered in a small in-order queue. The head issues as a registered
//   one-cycle pulse whenever the ROB and its target unit (RS or LSB) can
//   take it. A CDB flush empties the queue and blocks fetch for a recovery
//   window.
//
// Parameters
//   DEPTH                 queue entries (power of two, >= 2)
//   FLUSH_RECOVER_CYCLES  cycles with fetch blocked after a flush (>= 1)
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   rdy                   global enable; low freezes all state and outputs
//   if_valid/if_instr/if_pc/if_jumped/if_is_lsb   fetch side offer
//   if_ready              combinational accept toward fetch
//   rob_full/rs_full/lsb_full  back-pressure, already covering one in-flight issue
//   iss_valid/iss_instr/iss_pc/iss_jumped/iss_is_lsb  registered issue pulse
//   flush                 misprediction flush from the CDB
//
// Optional build macro
//   DISPATCH_STALL_STATS_EN  adds stall_cycles[31:0] and flush_count[15:0],
//                            saturating counters cleared by rst.
//
// State table
//   IDLE    | queue empty, nothing to issue
//   ISSUE   | head issues every cycle it is unblocked
//   STALL   | head blocked by a full ROB/RS/LSB
//   RECOVER | post-flush window; fetch blocked, no issue

module dispatch_controller #(
    parameter int DEPTH                = 4,
    parameter int FLUSH_RECOVER_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        if_jumped,
    input  logic        if_is_lsb,
    output logic        if_ready,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        iss_valid,
    output logic [31:0] iss_instr,
    output logic [31:0] iss_pc,
    output logic        iss_jumped,
    output logic        iss_is_lsb,
    input  logic        flush
`ifdef DISPATCH_STALL_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FLUSH_RECOVER_CYCLES > 1) ? $clog2(FLUSH_RECOVER_CYCLES) : 1;

    localparam logic [AW:0]   DEPTH_C      = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] RECOVER_LOAD = CW'(FLUSH_RECOVER_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_STALL   = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    logic [31:0]   r_q_instr  [DEPTH];
    logic [31:0]   r_q_pc     [DEPTH];
    logic          r_q_jumped [DEPTH];
    logic          r_q_is_lsb [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [CW-1:0] r_rec_cnt;

    logic          w_active;
    logic          w_blocked;
    logic          w_issue;
    logic          w_push;
    logic [AW:0]   w_count_next;
    logic [1:0]    w_state_next;
    logic [CW-1:0] w_rec_next;

    assign if_ready  = (r_count < DEPTH_C) && (r_state != ST_RECOVER);
    assign w_active  = rdy && !flush;
    assign w_blocked = rob_full || (r_q_is_lsb[r_head] ? lsb_full : rs_full);
    assign w_issue   = w_active && ((r_state == ST_ISSUE) || (r_state == ST_STALL))
                       && (r_count != '0) && !w_blocked;
    // if_ready looks only at the pre-edge count, so a full queue refuses a
    // push even in a cycle where it also pops.
    assign w_push    = w_active && if_valid && if_ready;
    assign w_count_next = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_issue);

    always_comb begin
        w_state_next = r_state;
        w_rec_next   = r_rec_cnt;
        if (flush) begin
            w_state_next = ST_RECOVER;
            w_rec_next   = RECOVER_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_count_next != '0) w_state_next = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if ((r_count != '0) && w_blocked) w_state_next = ST_STALL;
                    else if (w_count_next == '0)      w_state_next = ST_IDLE;
                end
                ST_STALL: begin
                    if (!w_blocked) w_state_next = ST_ISSUE;
                end
                default: begin
                    if (r_rec_cnt == '0) w_state_next = ST_IDLE;
                    else                 w_rec_next   = r_rec_cnt - 1'b1;
                end
            endcase
        end
    end

    // Queue storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_tail]  <= if_instr;
            r_q_pc[r_tail]     <= if_pc;
            r_q_jumped[r_tail] <= if_jumped;
            r_q_is_lsb[r_tail] <= if_is_lsb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_state   <= ST_IDLE;
            r_rec_cnt <= '0;
        end else if (rdy) begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_next;
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)  r_tail <= r_tail + 1'b1;
                if (w_issue) r_head <= r_head + 1'b1;
                r_count <= w_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_instr  <= '0;
            iss_pc     <= '0;
            iss_jumped <= 1'b0;
            iss_is_lsb <= 1'b0;
        end else if (rdy) begin
            iss_valid <= w_issue;
            if (w_issue) begin
                iss_instr  <= r_q_instr[r_head];
                iss_pc     <= r_q_pc[r_head];
                iss_jumped <= r_q_jumped[r_head];
                iss_is_lsb <= r_q_is_lsb[r_head];
            end
        end
    end

`ifdef DISPATCH_STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (rdy) begin
            if ((r_state == ST_STALL) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (flush && (flush_count != '1))                  flush_count  <= flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_controller.sv
// Bench for dispatch_controller: a directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based
// reference model.

module tb_dispatch_controller;

    localparam int DEPTH = 4;
    localparam int RECOV = 1;

    logic        clk = 1'b0;
    logic        rst, rdy, if_valid, if_jumped, if_is_lsb, if_ready;
    logic [31:0] if_instr, if_pc;
    logic        rob_full, rs_full, lsb_full, flush;
    logic        iss_valid, iss_jumped, iss_is_lsb;
    logic [31:0] iss_instr, iss_pc;
`ifdef DISPATCH_STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    dispatch_controller #(.DEPTH(DEPTH), .FLUSH_RECOVER_CYCLES(RECOV)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_jumped(if_jumped), .if_is_lsb(if_is_lsb), .if_ready(if_ready),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .iss_valid(iss_valid), .iss_instr(iss_instr), .iss_pc(iss_pc),
        .iss_jumped(iss_jumped), .iss_is_lsb(iss_is_lsb), .flush(flush)
`ifdef DISPATCH_STALL_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jumped;
        logic        is_lsb;
    } ent_t;

    ent_t        mq[$];
    int          m_rec;
    logic        m_iv;
    ent_t        m_iss;
    logic        m_stalled;
    logic [31:0] m_stall_cnt;
    logic [15:0] m_flush_cnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return (mq.size() < DEPTH) && (m_rec == 0);
    endfunction

    // Reference: a plain FIFO; the head leaves when the resources allow,
    // nothing enters during the recovery window.
    task automatic model_step();
        logic do_push, can;
        if (rst) begin
            mq.delete();
            m_rec = 0; m_iv = 1'b0; m_iss = '0; m_stalled = 1'b0;
            m_stall_cnt = '0; m_flush_cnt = '0;
            return;
        end
        if (!rdy) return;
        if (m_stalled && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0; m_rec = RECOV; m_stalled = 1'b0;
            if (m_flush_cnt != 16'hFFFF) m_flush_cnt++;
            return;
        end
        do_push = if_valid && exp_ready();
        can = (m_rec == 0) && (mq.size() > 0) && !rob_full
              && !(mq[0].is_lsb ? lsb_full : rs_full);
        m_stalled = (m_rec == 0) && (mq.size() > 0) && !can;
        if (can) begin
            m_iss = mq.pop_front();
            m_iv  = 1'b1;
        end else begin
            m_iv = 1'b0;
        end
        if (do_push) mq.push_back({if_instr, if_pc, if_jumped, if_is_lsb});
        if (m_rec > 0) m_rec--;
    endtask

    task automatic tick();
        #1;
        if (!rst) chk("if_ready", {31'b0, if_ready}, {31'b0, exp_ready()});
        model_step();
        @(posedge clk);
        #1;
        chk("iss_valid",  {31'b0, iss_valid},  {31'b0, m_iv});
        chk("iss_instr",  iss_instr,           m_iss.instr);
        chk("iss_pc",     iss_pc,              m_iss.pc);
        chk("iss_jumped", {31'b0, iss_jumped}, {31'b0, m_iss.jumped});
        chk("iss_is_lsb", {31'b0, iss_is_lsb}, {31'b0, m_iss.is_lsb});
`ifdef DISPATCH_STALL_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall_cnt);
        chk("flush_count",  {16'b0, flush_count}, {16'b0, m_flush_cnt});
`endif
    endtask

    task automatic quiet();
        rst = 0; rdy = 1; if_valid = 0; if_jumped = 0; if_is_lsb = 0;
        rob_full = 0; rs_full = 0; lsb_full = 0; flush = 0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic lsb);
        if_valid = 1; if_pc = pc; if_instr = pc ^ 32'h1300_0013;
        if_jumped = pc[2]; if_is_lsb = lsb;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; tick(); tick(); rst = 0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        lsb, rsf, lsbf, robf;
        logic        exp_rdy, exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        if_instr = '0; if_pc = '0;
        //            v  pc     lsb rsf lsbf robf  rdy iv exp_pc
        tbl[0]  = '{1, 32'h00, 0, 0, 0, 0, 1, 0, 32'h00};
        tbl[1]  = '{1, 32'h04, 0, 0, 0, 0, 1, 1, 32'h00};
        tbl[2]  = '{1, 32'h08, 0, 0, 0, 0, 1, 1, 32'h04};
        tbl[3]  = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h08};
        tbl[4]  = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h00};
        tbl[5]  = '{1, 32'h10, 0, 1, 0, 0, 1, 0, 32'h00};
        tbl[6]  = '{1, 32'h14, 0, 1, 0, 0, 1, 0, 32'h00};
        tbl[7]  = '{1, 32'h18, 0, 1, 0, 0, 1, 0, 32'h00};
        tbl[8]  = '{1, 32'h1c, 0, 1, 0, 0, 1, 0, 32'h00};
        tbl[9]  = '{1, 32'h3c, 0, 1, 0, 0, 0, 0, 32'h00};
        tbl[10] = '{0, 32'h00, 0, 0, 0, 0, 0, 1, 32'h10};
        tbl[11] = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h14};
        tbl[12] = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h18};
        tbl[13] = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h1c};
        tbl[14] = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h00};
        tbl[15] = '{1, 32'h20, 1, 0, 1, 0, 1, 0, 32'h00};
        tbl[16] = '{1, 32'h24, 0, 0, 1, 0, 1, 0, 32'h00};
        tbl[17] = '{0, 32'h00, 0, 0, 1, 0, 1, 0, 32'h00};
        tbl[18] = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h20};
        tbl[19] = '{0, 32'h00, 0, 0, 0, 0, 1, 1, 32'h24};
        tbl[20] = '{0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h00};

        do_reset();
        chk("reset_iss_valid", {31'b0, iss_valid}, 32'd0);
        chk("reset_iss_pc", iss_pc, 32'd0);
        chk("reset_if_ready", {31'b0, if_ready}, 32'd1);

        foreach (tbl[i]) begin
            quiet();
            if (tbl[i].v) offer(tbl[i].pc, tbl[i].lsb);
            rs_full = tbl[i].rsf; lsb_full = tbl[i].lsbf; rob_full = tbl[i].robf;
            #1;
            chk($sformatf("tbl%0d_if_ready", i), {31'b0, if_ready}, {31'b0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("tbl%0d_iss_valid", i), {31'b0, iss_valid}, {31'b0, tbl[i].exp_iv});
            if (tbl[i].exp_iv) chk($sformatf("tbl%0d_iss_pc", i), iss_pc, tbl[i].exp_pc);
        end

        // Flush with three entries held and a push offered alongside.
        quiet(); rob_full = 1;
        for (int k = 0; k < 3; k++) begin
            offer(32'h40 + 32'(4 * k), 1'b0); tick();
        end
        offer(32'h99, 1'b0); flush = 1; tick();
        chk("flush_iss_valid", {31'b0, iss_valid}, 32'd0);
        chk("flush_if_ready_blocked", {31'b0, if_ready}, 32'd0);
        quiet(); tick();
        chk("recover_if_ready_back", {31'b0, if_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_flush_no_issue", {31'b0, iss_valid}, 32'd0);
        end

        // rdy low freezes outputs and pointers.
        quiet(); rob_full = 1;
        for (int k = 0; k < 3; k++) begin
            offer(32'h50 + 32'(4 * k), 1'b0); tick();
        end
        quiet(); tick();
        chk("pre_hold_iss_pc", iss_pc, 32'h50);
        rdy = 0; offer(32'h77, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_iss_valid", {31'b0, iss_valid}, 32'd1);
            chk("hold_iss_pc", iss_pc, 32'h50);
        end
        quiet(); tick();
        chk("resume_pc0", iss_pc, 32'h54);
        tick();
        chk("resume_pc1", iss_pc, 32'h58);
        tick();
        chk("resume_drained", {31'b0, iss_valid}, 32'd0);

`ifdef DISPATCH_STALL_STATS_EN
        do_reset();
        offer(32'h60, 1'b0); tick();
        quiet(); rob_full = 1;
        for (int k = 0; k < 10; k++) tick();
        rob_full = 0; tick();
        chk("stats_stall_10", stall_cycles, 32'd10);
        flush = 1; tick(); flush = 0; tick(); flush = 1; tick(); flush = 0; tick();
        chk("stats_flush_2", {16'b0, flush_count}, 32'd2);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 499) == 0);
            rdy      = ($urandom_range(0, 99) < 85);
            flush    = ($urandom_range(0, 99) < 3);
            rob_full = ($urandom_range(0, 99) < 20);
            rs_full  = ($urandom_range(0, 99) < 25);
            lsb_full = ($urandom_range(0, 99) < 25);
            if_valid = ($urandom_range(0, 99) < 60);
            if_instr = $urandom;
            if_pc    = $urandom;
            if_jumped = $urandom_range(0, 1);
            if_is_lsb = $urandom_range(0, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
